// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types: forwarding selects, memory handshake FSM states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_fsm_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory request/ready handshake between the M-stage control and memory.
interface hazard_ctrl_if;
  logic mem_valid;
  logic mem_ready;

  modport master (output mem_valid, input  mem_ready);
  modport slave  (input  mem_valid, output mem_ready);
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// E-stage operand forwarding select for one source register; M beats W, x0 never forwards.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && rd_m != ZERO && rd_m == rs_e)
      sel = FWD_M;
    else if (reg_write_w && rd_w != ZERO && rd_w == rs_e)
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: stall/flush controls, forwarding selects,
// multi-cycle data-memory handshake FSM and saturating stall counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic              mem_req_m,
  hazard_ctrl_if.master     mem,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  lu_cnt
);

  localparam int NUM_OPS = 2;
  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  mem_fsm_t                      state_q, state_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]              lu_cnt_q, lu_cnt_d;
  logic                          lw_stall, mem_stall, mem_valid;
  logic [NUM_OPS-1:0][REG_AW-1:0] rs_e;
  logic [NUM_OPS-1:0][1:0]       fwd_sel;

  assign rs_e = {rs2_e, rs1_e};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
      .rs_e        (rs_e[i]),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .sel         (fwd_sel[i])
    );
  end

  assign fwd_a_e = fwd_sel[0];
  assign fwd_b_e = fwd_sel[1];

  // Once issued the request stays up in WAIT; reset abandons it immediately.
  assign mem_valid     = reset_n & ((state_q == WAIT) | mem_req_m);
  assign mem.mem_valid = mem_valid;
  assign mem_stall     = mem_valid & ~mem.mem_ready;

  assign lw_stall = load_e & (rd_e != ZERO) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  assign stall_m = mem_stall;
  assign stall_e = mem_stall;
  assign stall_f = mem_stall | lw_stall;
  assign stall_d = mem_stall | lw_stall;
  assign flush_w = mem_stall;
  // A frozen E holds any branch/load-use; they resolve on the release cycle.
  assign flush_e = (lw_stall | pc_src_e) & ~mem_stall;
  assign flush_d = pc_src_e & ~mem_stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_req_m && !mem.mem_ready) state_d = WAIT;
      WAIT: if (mem.mem_ready)               state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (stall_f && !(&stall_cnt_q))         stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (lw_stall && !mem_stall && !(&lu_cnt_q)) lu_cnt_d = lu_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign lu_cnt    = lu_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cnt, lu_cnt;

  hazard_ctrl_if mif ();

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m),
    .mem(mif.master),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_cnt(stall_cnt), .lu_cnt(lu_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: is a memory access outstanding, plus plain integer counts.
  bit m_busy = 1'b0;
  int m_stall = 0;
  int m_lu    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ctrl_vec();
    return {mif.mem_valid, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  // Called at posedge+1 with inputs applied; checks, clocks, advances the model.
  task automatic eval_cycle();
    logic mv, ms, lw;
    #1;
    mv = m_busy || mem_req_m;
    ms = mv && !mif.mem_ready;
    lw = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    check("ctrl", 32'(ctrl_vec()),
          32'({mv, ms|lw, ms|lw, ms, ms, pc_src_e & ~ms, (lw|pc_src_e) & ~ms, ms}));
    check("fwd_a", 32'(fwd_a_e), 32'(ref_fwd(rs1_e)));
    check("fwd_b", 32'(fwd_b_e), 32'(ref_fwd(rs2_e)));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("lu_cnt", 32'(lu_cnt), 32'(m_lu));
    @(posedge clk); #1;
    if ((ms || lw) && m_stall < CMAX) m_stall++;
    if (lw && !ms && m_lu < CMAX) m_lu++;
    m_busy = ms;
  endtask

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m} = '0;
    mif.mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #12;
    check("reset_ctrl", 32'(ctrl_vec()), 32'(0));
    check("reset_fwd", 32'({fwd_a_e, fwd_b_e}), 32'(0));
    check("reset_cnt", 32'({stall_cnt, lu_cnt}), 32'(0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding priority and x0 suppression
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
    #1 check("fwd_m_prio", 32'(fwd_a_e), 32'(2'b10));
    eval_cycle();
    rd_m = 0;
    #1 check("fwd_w", 32'(fwd_a_e), 32'(2'b01));
    eval_cycle();
    rs1_e = 0;
    #1 check("fwd_rf", 32'(fwd_a_e), 32'(2'b00));
    eval_cycle();
    clear_inputs();

    // Load-use bubble
    load_e = 1; rd_e = 7; rs2_d = 7;
    #1 check("lu_stall", 32'({stall_f, stall_d, flush_e}), 32'(3'b111));
    eval_cycle();
    check("lu_cnt_inc", 32'(lu_cnt), 32'(1));
    load_e = 0;
    eval_cycle();
    check("lu_after", 32'(ctrl_vec()), 32'(0));

    // Three-cycle memory wait then release
    mem_req_m = 1; mif.mem_ready = 0;
    repeat (3) eval_cycle();
    mif.mem_ready = 1;
    #1 check("mem_release", 32'({mif.mem_valid, stall_f, stall_m, flush_w}), 32'(4'b1000));
    eval_cycle();
    check("mem_wait_cnt", 32'(stall_cnt), 32'(4));
    mem_req_m = 0; mif.mem_ready = 0;
    #1 check("mem_idle", 32'(mif.mem_valid), 32'(0));
    eval_cycle();

    // Single-cycle hit
    mem_req_m = 1; mif.mem_ready = 1;
    #1 check("hit", 32'({mif.mem_valid, stall_f, stall_e}), 32'(3'b100));
    eval_cycle();
    mem_req_m = 0; mif.mem_ready = 0;
    eval_cycle();

    // Request glitches low while waiting: must stay committed
    mem_req_m = 1;
    eval_cycle();
    mem_req_m = 0;
    #1 check("req_glitch", 32'({mif.mem_valid, stall_m}), 32'(2'b11));
    eval_cycle();
    mif.mem_ready = 1;
    eval_cycle();
    mif.mem_ready = 0;

    // Branch under memory stall is held, then flushes on release
    mem_req_m = 1; pc_src_e = 1;
    #1 check("br_held", 32'({flush_d, flush_e}), 32'(0));
    eval_cycle();
    mif.mem_ready = 1;
    #1 check("br_release", 32'({flush_d, flush_e}), 32'(2'b11));
    eval_cycle();
    clear_inputs();

    // Load-use together with a taken branch
    load_e = 1; rd_e = 2; rs1_d = 2; pc_src_e = 1;
    #1 check("lu_br", 32'({stall_f, stall_d, flush_d, flush_e}), 32'(4'b1111));
    eval_cycle();
    clear_inputs();

    // Asynchronous reset in the middle of WAIT
    mem_req_m = 1;
    eval_cycle();
    #1 mem_req_m = 0;
    #1 check("pre_rst_wait", 32'(mif.mem_valid), 32'(1));
    reset_n = 0;
    #1 check("rst_wait_valid", 32'(mif.mem_valid), 32'(0));
    check("rst_wait_cnt", 32'({stall_cnt, lu_cnt}), 32'(0));
    m_busy = 0; m_stall = 0; m_lu = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // Counter saturation
    load_e = 1; rd_e = 3; rs1_d = 3;
    repeat (CMAX + 4) eval_cycle();
    check("sat_lu", 32'(lu_cnt), 32'(CMAX));
    check("sat_stall", 32'(stall_cnt), 32'(CMAX));
    clear_inputs();
    reset_n = 0;
    #1 m_busy = 0; m_stall = 0; m_lu = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      rs1_d = AW'($urandom_range(3)); rs2_d = AW'($urandom_range(3));
      rs1_e = AW'($urandom_range(3)); rs2_e = AW'($urandom_range(3));
      rd_e  = AW'($urandom_range(3)); rd_m  = AW'($urandom_range(3));
      rd_w  = AW'($urandom_range(3));
      reg_write_m   = 1'($urandom_range(1));
      reg_write_w   = 1'($urandom_range(1));
      load_e        = ($urandom_range(3) == 0);
      pc_src_e      = ($urandom_range(7) == 0);
      mem_req_m     = ($urandom_range(2) == 0);
      mif.mem_ready = 1'($urandom_range(1));
      eval_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
